// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the fetch/decode/execute controller.
// Opcodes, branch conditions, ULA and constant-mux encodings used by decoder and FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_CMPI = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] COND_LT     = 4'd0;
  localparam logic [3:0] COND_LE     = 4'd1;
  localparam logic [3:0] COND_EQ     = 4'd2;
  localparam logic [3:0] COND_GE     = 4'd3;
  localparam logic [3:0] COND_GT     = 4'd4;
  localparam logic [3:0] COND_ALWAYS = 4'd5;

  localparam logic [3:0] ULA_PASS_A = 4'h8;

  localparam logic [1:0] SEL_REGS   = 2'b00;
  localparam logic [1:0] SEL_CTE_A  = 2'b01;
  localparam logic [1:0] SEL_CTE_B  = 2'b10;
  localparam logic [1:0] SEL_CTE_AB = 2'b11;

  // Flags are ordered [0]lt [1]le [2]eq [3]ge [4]gt; conditions above 5 never branch.
  function automatic logic branch_taken(input logic [3:0] cond, input logic [4:0] flags);
    logic taken;
    case (cond)
      COND_LT:     taken = flags[0];
      COND_LE:     taken = flags[1];
      COND_EQ:     taken = flags[2];
      COND_GE:     taken = flags[3];
      COND_GT:     taken = flags[4];
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decode: IR fields to datapath control lines and class flags.
// Branches, HALT, NOP and undefined opcodes drive all datapath fields to zero.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [19:0] ir_i,
  output logic [3:0]  srd_o,
  output logic [3:0]  sba_o,
  output logic [3:0]  sbb_o,
  output logic [3:0]  sula_o,
  output logic [1:0]  sel_o,
  output logic [7:0]  cte_o,
  output logic [3:0]  cond_o,
  output logic [7:0]  imm_o,
  output logic        writes_reg_o,
  output logic        is_cmp_o,
  output logic        is_br_o,
  output logic        is_halt_o,
  output logic        illegal_o
);

  logic [3:0] op_s;
  logic [3:0] f_s;
  logic [3:0] rd_s;
  logic [3:0] ra_s;
  logic [3:0] rb_s;

  assign op_s   = ir_i[19:16];
  assign f_s    = ir_i[15:12];
  assign rd_s   = ir_i[11:8];
  assign ra_s   = ir_i[7:4];
  assign rb_s   = ir_i[3:0];
  assign imm_o  = ir_i[7:0];
  assign cond_o = f_s;

  // Opcode to control-field mapping
  always_comb begin
    srd_o        = 4'h0;
    sba_o        = 4'h0;
    sbb_o        = 4'h0;
    sula_o       = 4'h0;
    sel_o        = SEL_REGS;
    cte_o        = 8'h00;
    writes_reg_o = 1'b0;
    is_cmp_o     = 1'b0;
    is_br_o      = 1'b0;
    is_halt_o    = 1'b0;
    illegal_o    = 1'b0;
    case (op_s)
      OP_NOP: begin
      end
      OP_ALU: begin
        srd_o        = rd_s;
        sba_o        = ra_s;
        sbb_o        = rb_s;
        sula_o       = f_s;
        writes_reg_o = 1'b1;
      end
      OP_ALUI: begin
        srd_o        = rd_s;
        sba_o        = rd_s;
        sula_o       = f_s;
        cte_o        = ir_i[7:0];
        sel_o        = SEL_CTE_B;
        writes_reg_o = 1'b1;
      end
      OP_LDI: begin
        srd_o        = rd_s;
        cte_o        = ir_i[7:0];
        sel_o        = SEL_CTE_AB;
        sula_o       = ULA_PASS_A;
        writes_reg_o = 1'b1;
      end
      OP_CMP: begin
        sba_o    = ra_s;
        sbb_o    = rb_s;
        is_cmp_o = 1'b1;
      end
      OP_CMPI: begin
        sba_o    = rd_s;
        cte_o    = ir_i[7:0];
        sel_o    = SEL_CTE_B;
        is_cmp_o = 1'b1;
      end
      OP_BR:   is_br_o   = 1'b1;
      OP_HALT: is_halt_o = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller driving the 8-bit datapath.
// Owns the FSM, PC, IR and comparator-flag registers; decode is delegated to ctrl_decoder.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int IW = 20,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic [4:0]    outComparator,
  output logic [3:0]    SRD,
  output logic [3:0]    SBA,
  output logic [3:0]    SBB,
  output logic [3:0]    SULA,
  output logic [1:0]    selMuxCTE,
  output logic [7:0]    CTE,
  output logic          LE,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          illegal_op
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [4:0]    flags_q, flags_d;

  logic [3:0] cond_s;
  logic [7:0] imm_s;
  logic       writes_reg_s;
  logic       is_cmp_s;
  logic       is_br_s;
  logic       is_halt_s;
  logic       illegal_s;

  ctrl_decoder u_decoder (
    .ir_i         (ir_q),
    .srd_o        (SRD),
    .sba_o        (SBA),
    .sbb_o        (SBB),
    .sula_o       (SULA),
    .sel_o        (selMuxCTE),
    .cte_o        (CTE),
    .cond_o       (cond_s),
    .imm_o        (imm_s),
    .writes_reg_o (writes_reg_s),
    .is_cmp_o     (is_cmp_s),
    .is_br_o      (is_br_s),
    .is_halt_o    (is_halt_s),
    .illegal_o    (illegal_s)
  );

  // State, PC, IR and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= 5'b00000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Next-state, fetch capture and execute-time PC/flag updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + AW'(1);
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_cmp_s) flags_d = outComparator;
        else          flags_d = flags_q;
        // A taken branch replaces the increment already applied during fetch.
        if (is_br_s && branch_taken(cond_s, flags_q)) pc_d = AW'(imm_s);
        else                                          pc_d = pc_q;
        if (is_halt_s) state_d = ST_HALT;
        else           state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Derived straight from the async-reset state so imem_req falls as soon as reset asserts.
  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign LE         = (state_q == ST_EXEC) && writes_reg_s;
  assign illegal_op = (state_q == ST_EXEC) && illegal_s;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the memory driver queues the expected decode per fetch,
// and a monitor pops and checks it when the DUT requests, decodes and executes that fetch.
module tb_control_unit;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [19:0] imem_data;
  logic [4:0]  outComparator;
  logic [3:0]  SRD, SBA, SBB, SULA;
  logic [1:0]  selMuxCTE;
  logic [7:0]  CTE;
  logic        LE;
  logic [7:0]  pc;
  logic        halted;
  logic        illegal_op;

  always #5 clk = ~clk;

  control_unit #(.IW(20), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .outComparator(outComparator),
    .SRD(SRD), .SBA(SBA), .SBB(SBB), .SULA(SULA), .selMuxCTE(selMuxCTE), .CTE(CTE),
    .LE(LE), .pc(pc), .halted(halted), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [7:0] addr;
    logic [3:0] srd, sba, sbb, sula;
    logic [1:0] sel;
    logic [7:0] cte;
    logic       le, ill, hlt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] addr, input logic [3:0] srd, input logic [3:0] sba,
                              input logic [3:0] sbb, input logic [3:0] sula, input logic [1:0] sel,
                              input logic [7:0] cte, input logic le, input logic ill, input logic hlt);
    exp_t e;
    e.addr = addr; e.srd = srd; e.sba = sba; e.sbb = sbb; e.sula = sula;
    e.sel = sel; e.cte = cte; e.le = le; e.ill = ill; e.hlt = hlt;
    return e;
  endfunction

  task automatic check_ctrl(input string tag, input exp_t e, input logic le_exp, input logic ill_exp);
    chk({tag, "_SRD"}, SRD, e.srd);
    chk({tag, "_SBA"}, SBA, e.sba);
    chk({tag, "_SBB"}, SBB, e.sbb);
    chk({tag, "_SULA"}, SULA, e.sula);
    chk({tag, "_sel"}, selMuxCTE, e.sel);
    chk({tag, "_CTE"}, CTE, e.cte);
    chk({tag, "_LE"}, LE, le_exp);
    chk({tag, "_illegal"}, illegal_op, ill_exp);
  endtask

  // Memory driver: queue the expectation, wait for the request, ack after wait_cyc cycles.
  task automatic issue(input exp_t e, input logic [19:0] instr, input int wait_cyc);
    int n = 0;
    q.push_back(e);
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      checks++;
      failures++;
      $display("FAIL fetch_timeout actual=no_request required=request addr=%0h", e.addr);
      return;
    end
    repeat (wait_cyc) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 20'h00000;
  endtask

  // Monitor: one queued expectation per fetch request
  initial begin
    exp_t e;
    logic [7:0] nxt;
    forever begin
      @(negedge clk);
      if (mon_en && imem_req) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch actual=%0h required=none", imem_addr);
        end else begin
          e = q.pop_front();
          chk("fetch_addr", imem_addr, e.addr);
          forever begin
            @(posedge clk);
            if (imem_ack) break;
            @(negedge clk);
            chk("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, e.addr);
          end
          #1;
          nxt = e.addr + 8'd1;
          check_ctrl("decode", e, 1'b0, 1'b0);
          chk("pc_decode", pc, nxt);
          @(posedge clk);
          #1;
          check_ctrl("exec", e, e.le, e.ill);
          if (e.hlt) begin
            @(posedge clk);
            #1;
            chk("halted", halted, 1'b1);
            chk("halt_noreq", imem_req, 1'b0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 20'h00000;
    outComparator = 5'b00011;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_ctrl", {SRD, SBA, SBB, SULA, selMuxCTE, CTE}, 32'h0);
    chk("rst_LE", LE, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);

    // Reset while a fetch is outstanding
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_started", imem_req, 1'b1);
    repeat (2) @(negedge clk);
    chk("req_waiting", imem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("req_drops_on_reset", imem_req, 1'b0);
    chk("pc_on_reset", pc, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mon_en = 1'b1;
    start  = 1'b1;
    fork
      begin
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    issue(mk(8'h00, 4'd2, 4'd1, 4'd0, 4'd3, SEL_REGS, 8'h00, 1'b1, 1'b0, 1'b0), 20'h13210, 0);
    issue(mk(8'h01, 4'd4, 4'd0, 4'd0, ULA_PASS_A, SEL_CTE_AB, 8'h5A, 1'b1, 1'b0, 1'b0), 20'h3045A, 3);
    issue(mk(8'h02, 4'd0, 4'd1, 4'd0, 4'd0, SEL_CTE_B, 8'h5A, 1'b0, 1'b0, 1'b0), 20'h6015A, 0);
    issue(mk(8'h03, 4'd0, 4'd0, 4'd0, 4'd0, SEL_REGS, 8'h00, 1'b0, 1'b0, 1'b0), 20'h70040, 0);
    issue(mk(8'h40, 4'd0, 4'd1, 4'd0, 4'd0, SEL_CTE_B, 8'h5A, 1'b0, 1'b0, 1'b0), 20'h6015A, 1);
    issue(mk(8'h41, 4'd0, 4'd0, 4'd0, 4'd0, SEL_REGS, 8'h00, 1'b0, 1'b0, 1'b0), 20'h74040, 0);
    issue(mk(8'h42, 4'd0, 4'd0, 4'd0, 4'd0, SEL_REGS, 8'h00, 1'b0, 1'b1, 1'b0), 20'h91234, 0);
    issue(mk(8'h43, 4'd0, 4'd0, 4'd0, 4'd0, SEL_REGS, 8'h00, 1'b0, 1'b0, 1'b0), 20'h750FF, 0);
    issue(mk(8'hFF, 4'd3, 4'd3, 4'd0, 4'hA, SEL_CTE_B, 8'hC7, 1'b1, 1'b0, 1'b0), 20'h2A3C7, 2);
    issue(mk(8'h00, 4'd0, 4'd0, 4'd0, 4'd0, SEL_REGS, 8'h00, 1'b0, 1'b0, 1'b1), 20'hF0000, 0);
    repeat (4) @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_ignores_start", halted, 1'b1);
    chk("halt_no_fetch", imem_req, 1'b0);
    chk("halt_pc", pc, 8'h01);

    #1 rst_n = 1'b0;
    #1;
    chk("post_halt_reset_halted", halted, 1'b0);
    chk("post_halt_reset_pc", pc, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset_req", imem_req, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
